// File: rtl/spart_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPART register port.
// Blocked TX/RX accesses wait without stalling the other requester and are error-acked after WAIT_LIMIT cycles.
module spart_arbiter #(
    parameter logic [15:0] WAIT_LIMIT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] we,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic [1:0] ack,
    output logic       err,
    output logic [7:0] rdata,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t      state_q;
    logic        winner_q;
    logic        last_q;
    logic [7:0]  wdata_q;
    logic        drive_q;
    logic [1:0]  ack_q;
    logic        err_q;
    logic [7:0]  rdata_q;
    logic        iocs_q;
    logic        iorw_q;
    logic [1:0]  ioaddr_q;
    logic [15:0] wcnt0_q, wcnt1_q;
    logic [15:0] wcnt0_d, wcnt1_d;

    logic [1:0]  blocked;
    logic [1:0]  elig;
    logic [1:0]  tmo;
    logic        grant_win;
    logic        tmo_win;
    logic        sel_we;
    logic [1:0]  sel_addr;
    logic [7:0]  sel_wdata;

    // Both candidates present: the one not granted last time wins.
    function automatic logic pick(input logic [1:0] cand, input logic last);
        if (cand == 2'b11) return ~last;
        return cand[1];
    endfunction

    function automatic logic [15:0] next_cnt(input logic [15:0] cnt, input logic r,
                                             input logic blk, input logic done);
        if (!r || done) return 16'd0;
        if (blk && cnt != 16'hFFFF) return cnt + 16'd1;
        return cnt;
    endfunction

    // TX writes need a free transmit buffer, RX reads need received data.
    assign blocked[0] = (addr0 == 2'b00) && (we[0] ? !tbr : !rda);
    assign blocked[1] = (addr1 == 2'b00) && (we[1] ? !tbr : !rda);
    assign elig       = req & ~blocked;
    assign tmo[0]     = req[0] && (wcnt0_q >= WAIT_LIMIT);
    assign tmo[1]     = req[1] && (wcnt1_q >= WAIT_LIMIT);
    assign grant_win  = pick(elig, last_q);
    assign tmo_win    = pick(tmo, last_q);
    assign sel_we     = grant_win ? we[1] : we[0];
    assign sel_addr   = grant_win ? addr1 : addr0;
    assign sel_wdata  = grant_win ? wdata1 : wdata0;

    assign wcnt0_d = next_cnt(wcnt0_q, req[0], blocked[0], (state_q == ACK) && !winner_q);
    assign wcnt1_d = next_cnt(wcnt1_q, req[1], blocked[1], (state_q == ACK) && winner_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            last_q   <= 1'b1;
            wdata_q  <= 8'h00;
            drive_q  <= 1'b0;
            ack_q    <= 2'b00;
            err_q    <= 1'b0;
            rdata_q  <= 8'h00;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= 2'b00;
            wcnt0_q  <= 16'd0;
            wcnt1_q  <= 16'd0;
        end else begin
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
            iocs_q  <= 1'b0;
            drive_q <= 1'b0;
            wcnt0_q <= wcnt0_d;
            wcnt1_q <= wcnt1_d;
            case (state_q)
                IDLE: begin
                    // A timed-out requester is aborted before any normal grant.
                    if (tmo != 2'b00) begin
                        winner_q <= tmo_win;
                        ack_q    <= tmo_win ? 2'b10 : 2'b01;
                        err_q    <= 1'b1;
                        state_q  <= ACK;
                    end else if (elig != 2'b00) begin
                        winner_q <= grant_win;
                        wdata_q  <= sel_wdata;
                        iocs_q   <= 1'b1;
                        iorw_q   <= ~sel_we;
                        ioaddr_q <= sel_addr;
                        drive_q  <= sel_we;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iorw_q) rdata_q <= databus;
                    ack_q   <= winner_q ? 2'b10 : 2'b01;
                    state_q <= ACK;
                end
                ACK: begin
                    last_q  <= winner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign databus   = drive_q ? wdata_q : 8'bzzzz_zzzz;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign iocs      = iocs_q;
    assign iorw      = iorw_q;
    assign ioaddr    = ioaddr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spart_arbiter.sv
// Scoreboard bench for spart_arbiter: directed requests push expected bus cycles and acks,
// a negedge monitor pops and compares whenever iocs or ack is seen.
module tb_spart_arbiter;

    localparam logic [15:0] WL = 16'd20;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_t = 1'b0, req1_t = 1'b0;
    logic       we0_t = 1'b0, we1_t = 1'b0;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       rda, tbr;
    wire  [1:0] ack;
    wire        err;
    wire  [7:0] rdata;
    wire        iocs;
    wire        iorw;
    wire  [1:0] ioaddr;
    wire  [7:0] databus;
    wire  [1:0] dbg_state;
    logic [7:0] model_val;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int ack_cnt = 0;
    int iocs_cnt = 0;
    // {check_rdata, ack[1:0], err, rdata[7:0]}
    logic [11:0] exp_ack_q[$];
    // {iorw, ioaddr[1:0], databus[7:0]}
    logic [10:0] exp_bus_q[$];
    int          ack_cyc_q[$];

    spart_arbiter #(.WAIT_LIMIT(WL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       ({req1_t, req0_t}),
        .we        ({we1_t, we0_t}),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .rda       (rda),
        .tbr       (tbr),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPART register model: drives the bus only during a read cycle.
    always_comb begin
        model_val = 8'h00;
        case (ioaddr)
            2'b00:   model_val = 8'h5A;
            2'b01:   model_val = 8'h03;
            default: model_val = 8'h00;
        endcase
    end
    assign databus = (iocs && iorw) ? model_val : 8'bzzzz_zzzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ack(input logic chk, input bit n, input logic e, input logic [7:0] rd);
        exp_ack_q.push_back({chk, (n ? 2'b10 : 2'b01), e, rd});
    endtask

    task automatic push_bus(input logic rw, input logic [1:0] a, input logic [7:0] d);
        exp_bus_q.push_back({rw, a, d});
    endtask

    task automatic monitor();
        logic [11:0] ea;
        logic [10:0] eb;
        forever begin
            @(negedge clk);
            if (iocs) begin
                iocs_cnt++;
                if (exp_bus_q.size() == 0) begin
                    total++;
                    $display("FAIL bus_unexpected: got iorw=%0b ioaddr=%0h databus=%0h, expected no cycle (cycle %0d)",
                             iorw, ioaddr, databus, cyc);
                end else begin
                    eb = exp_bus_q.pop_front();
                    check("bus_cycle", {21'd0, iorw, ioaddr, databus}, {21'd0, eb});
                end
            end
            if (ack != 2'b00) begin
                ack_cnt++;
                ack_cyc_q.push_back(cyc);
                if (exp_ack_q.size() == 0) begin
                    total++;
                    $display("FAIL ack_unexpected: got ack=%0b err=%0b, expected none (cycle %0d)", ack, err, cyc);
                end else begin
                    ea = exp_ack_q.pop_front();
                    check("ack_port", {30'd0, ack}, {30'd0, ea[10:9]});
                    check("ack_err", {31'd0, err}, {31'd0, ea[8]});
                    if (ea[11]) check("ack_rdata", {24'd0, rdata}, {24'd0, ea[7:0]});
                end
            end
        end
    endtask

    // Raise a request, wait (bounded) for its ack, then drop req the cycle after.
    task automatic run_req(input bit n, input logic w, input logic [1:0] a, input logic [7:0] d,
                           input int budget, output int lat);
        int start;
        int k;
        @(posedge clk);
        #1;
        if (!n) begin
            we0_t = w; addr0 = a; wdata0 = d; req0_t = 1'b1;
        end else begin
            we1_t = w; addr1 = a; wdata1 = d; req1_t = 1'b1;
        end
        start = cyc;
        k = 0;
        lat = -1;
        while (k < budget) begin
            @(negedge clk);
            k++;
            if (ack[n]) begin
                lat = cyc - start;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            $display("FAIL req%0d_wait: got no ack, expected ack within %0d cycles", n, budget);
        end
        @(posedge clk);
        #1;
        if (!n) req0_t = 1'b0;
        else req1_t = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat0, lat1, snap;
        rst = 1'b0; rda = 1'b0; tbr = 1'b1;
        addr0 = 2'b00; addr1 = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_iocs", {31'd0, iocs}, 32'd0);
        check("rst_iorw", {31'd0, iorw}, 32'd1);
        check("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_bus_z", {31'd0, (databus === 8'bzzzz_zzzz)}, 32'd1);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Both read status continuously: grants alternate 0,1,0,1 three cycles apart.
        ack_cyc_q.delete();
        for (int i = 0; i < 4; i++) begin
            push_bus(1'b1, 2'b01, 8'h03);
            push_ack(1'b1, i[0], 1'b0, 8'h03);
        end
        fork
            begin
                run_req(1'b0, 1'b0, 2'b01, 8'h00, 20, lat0);
                check("rr_first_latency", lat0, 32'd2);
                run_req(1'b0, 1'b0, 2'b01, 8'h00, 20, lat0);
            end
            begin
                run_req(1'b1, 1'b0, 2'b01, 8'h00, 20, lat1);
                run_req(1'b1, 1'b0, 2'b01, 8'h00, 20, lat1);
            end
        join
        check("rr_ack_count", ack_cyc_q.size(), 32'd4);
        if (ack_cyc_q.size() == 4) begin
            for (int i = 1; i < 4; i++) check("rr_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 32'd3);
        end

        // Plain divisor-low write.
        push_bus(1'b0, 2'b10, 8'h8B);
        push_ack(1'b0, 1'b0, 1'b0, 8'h00);
        run_req(1'b0, 1'b1, 2'b10, 8'h8B, 20, lat0);
        check("wr_latency", lat0, 32'd2);

        // Blocked TX write must not hold up a status read.
        tbr = 1'b0;
        push_bus(1'b1, 2'b01, 8'h03);
        push_ack(1'b1, 1'b0, 1'b0, 8'h03);
        push_bus(1'b0, 2'b00, 8'h3C);
        push_ack(1'b0, 1'b1, 1'b0, 8'h00);
        fork
            run_req(1'b1, 1'b1, 2'b00, 8'h3C, 60, lat1);
            begin
                repeat (2) @(posedge clk);
                run_req(1'b0, 1'b0, 2'b01, 8'h00, 20, lat0);
                check("bypass_latency", lat0, 32'd2);
                repeat (3) @(posedge clk);
                #1 tbr = 1'b1;
            end
        join

        // RX read with no data: error ack after the wait limit, no bus cycle.
        rda = 1'b0;
        snap = iocs_cnt;
        push_ack(1'b0, 1'b0, 1'b1, 8'h00);
        run_req(1'b0, 1'b0, 2'b00, 8'h00, 60, lat0);
        check("timeout_latency", lat0, {16'd0, WL} + 32'd1);
        check("timeout_no_iocs", iocs_cnt, snap);

        // Reset in the middle of a write cycle.
        @(posedge clk);
        #1;
        we0_t = 1'b1; addr0 = 2'b11; wdata0 = 8'h55; req0_t = 1'b1;
        @(posedge clk);
        #2;
        check("issue_iocs", {31'd0, iocs}, 32'd1);
        check("issue_bus", {24'd0, databus}, 32'h55);
        rst = 1'b0;
        #1;
        check("abort_iocs", {31'd0, iocs}, 32'd0);
        check("abort_bus_z", {31'd0, (databus === 8'bzzzz_zzzz)}, 32'd1);
        req0_t = 1'b0;
        snap = ack_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_ack", ack_cnt, snap);

        // First tie after reset goes to requester 0.
        push_bus(1'b1, 2'b01, 8'h03);
        push_ack(1'b1, 1'b0, 1'b0, 8'h03);
        push_bus(1'b1, 2'b01, 8'h03);
        push_ack(1'b1, 1'b1, 1'b0, 8'h03);
        fork
            run_req(1'b0, 1'b0, 2'b01, 8'h00, 20, lat0);
            run_req(1'b1, 1'b0, 2'b01, 8'h00, 20, lat1);
        join
        check("tie_after_rst_latency0", lat0, 32'd2);
        check("tie_after_rst_latency1", lat1, 32'd5);

        repeat (3) @(posedge clk);
        #1;
        check("ack_queue_drained", exp_ack_q.size(), 32'd0);
        check("bus_queue_drained", exp_bus_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
